line_capture: RTL

LINE_CAPTURE -- requirements
Module: line_capture

---
 rtl/plazer_pkg.sv | 14 +
 rtl/line_buf.sv | 26 ++
 rtl/line_capture.sv | 123 ++++++++++++
 3 files changed

// File: rtl/plazer_pkg.sv
// Shared constants and FSM state type for the line capture block.
package plazer_pkg;
  localparam int LINE_LEN_DEFAULT = 144;
  localparam int WORDS            = LINE_LEN_DEFAULT / 4;
  localparam int ADDR_W           = 11;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SOF,
    WAIT_LINE,
    CAPTURE,
    WRITE
  } state_t;
endpackage

// File: rtl/line_buf.sv
// One line of 8-bit pixels: byte writes during capture, 32-bit word reads during write-out.
module line_buf #(
  parameter int LINE_LEN = 144,
  parameter int IDX_W    = $clog2(LINE_LEN),
  parameter int K_W      = $clog2(LINE_LEN / 4 + 1)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [7:0]       wdata,
  input  logic [K_W-1:0]   raddr,
  output logic [31:0]      rdata
);
  logic [7:0]       mem [LINE_LEN];
  logic [IDX_W-1:0] base;

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  // The word index runs one past the end once the last word is loaded; clamp so the read stays in range.
  always_comb begin
    base = '0;
    if (raddr < K_W'(LINE_LEN / 4)) base = IDX_W'({raddr, 2'b00});
    rdata = {mem[base + IDX_W'(3)], mem[base + IDX_W'(2)], mem[base + IDX_W'(1)], mem[base]};
  end
endmodule

// File: rtl/line_capture.sv
// Captures one selected line of a pixel stream and writes it out over an Avalon-MM master.
module line_capture
  import plazer_pkg::*;
#(
  parameter int LINE_LEN  = LINE_LEN_DEFAULT,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [9:0]        line_sel,
  input  logic              pix_valid,
  input  logic [7:0]        pix_data,
  input  logic              pix_sof,
  input  logic              pix_sol,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_address,
  output logic [3:0]        m_byteenable,
  output logic [31:0]       m_writedata,
  input  logic              m_waitrequest,
  output logic              busy,
  output logic              done,
  output logic              err_short
);
  localparam int NWORDS = LINE_LEN / 4;
  localparam int IDX_W  = $clog2(LINE_LEN);
  localparam int K_W    = $clog2(NWORDS + 1);

  state_t           state, state_nxt;
  logic [9:0]       line_cnt, line_sel_q;
  logic [IDX_W-1:0] pix_idx;
  logic [K_W-1:0]   k;
  logic [IDX_W-1:0] buf_waddr;
  logic [31:0]      buf_rdata;
  logic sof, sol, line_hit, last_pix, acc, acc_last, load_word;
  logic cap_first, cap_next, cap_short;

  assign sof      = pix_valid & pix_sof;
  assign sol      = pix_valid & pix_sol;
  assign line_hit = sol & ~pix_sof & ((line_cnt + 10'd1) == line_sel_q);
  assign last_pix = (pix_idx == IDX_W'(LINE_LEN - 1));
  assign acc      = m_write & ~m_waitrequest;
  assign acc_last = acc & (k == K_W'(NWORDS));
  // A new word is loaded when the bus is empty or the current word is taken this cycle.
  assign load_word = (state == WRITE) & (~m_write | acc) & (k != K_W'(NWORDS));
  assign buf_waddr = cap_first ? '0 : pix_idx;

  assign busy         = (state != IDLE);
  assign m_byteenable = {4{m_write}};

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nxt;

  always_comb begin
    state_nxt = state;
    cap_first = 1'b0;
    cap_next  = 1'b0;
    cap_short = 1'b0;
    case (state)
      IDLE:      if (start && !done) state_nxt = WAIT_SOF;
      WAIT_SOF:  if (sof) begin
                   if (line_sel_q == 10'd0) begin
                     state_nxt = CAPTURE;
                     cap_first = 1'b1;
                   end else state_nxt = WAIT_LINE;
                 end
      WAIT_LINE: if (line_hit) begin
                   state_nxt = CAPTURE;
                   cap_first = 1'b1;
                 end
      CAPTURE:   if (sol) begin
                   state_nxt = IDLE;
                   cap_short = 1'b1;
                 end else if (pix_valid) begin
                   cap_next = 1'b1;
                   if (last_pix) state_nxt = WRITE;
                 end
      WRITE:     if (acc_last) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      line_cnt    <= '0;
      line_sel_q  <= '0;
      pix_idx     <= '0;
      k           <= '0;
      m_write     <= 1'b0;
      m_address   <= '0;
      m_writedata <= '0;
      done        <= 1'b0;
      err_short   <= 1'b0;
    end else begin
      done <= (state == WRITE) & acc_last;
      if (state == IDLE && start && !done) begin
        line_sel_q <= line_sel;
        err_short  <= 1'b0;
      end
      if (cap_short) err_short <= 1'b1;
      if (sof && (state == WAIT_SOF || state == WAIT_LINE)) line_cnt <= '0;
      else if (state == WAIT_LINE && sol)                   line_cnt <= line_cnt + 10'd1;
      if (cap_first)     pix_idx <= IDX_W'(1);
      else if (cap_next) pix_idx <= pix_idx + IDX_W'(1);
      if (state != WRITE) k <= '0;
      if (load_word) begin
        m_write     <= 1'b1;
        m_address   <= ADDR_W'(BASE_ADDR + 4 * int'(k));
        m_writedata <= buf_rdata;
        k           <= k + K_W'(1);
      end else if (acc) m_write <= 1'b0;
    end

  line_buf #(.LINE_LEN(LINE_LEN), .IDX_W(IDX_W), .K_W(K_W)) u_buf (
    .clk   (clk),
    .we    (cap_first | cap_next),
    .waddr (buf_waddr),
    .wdata (pix_data),
    .raddr (k),
    .rdata (buf_rdata)
  );
endmodule
